// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_pkg
//  Description : Shared types and encodings for the multi-cycle RV32I-subset
//                control unit: FSM states, ALU op codes, opcodes and the
//                datapath mux-select encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_ALU_WB   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WB   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;

  // Supported major opcodes
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // ALU operand A select
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  // ALU operand B select
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Register write-back source select
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] RES_PC     = 2'b11;

  // Immediate format select
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;

  // Immediate format implied by an opcode; unknown opcodes fall back to I
  function automatic logic [2:0] imm_src_of(input logic [6:0] op);
    logic [2:0] sel;
    case (op)
      OP_STORE:  sel = IMM_S;
      OP_BRANCH: sel = IMM_B;
      OP_JAL:    sel = IMM_J;
      default:   sel = IMM_I;
    endcase
    return sel;
  endfunction

endpackage : ctrl_pkg
`default_nettype wire

// File: rtl/alu_op_decode.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_decode
//  Description : Maps (opcode, funct3, funct7[5]) to the 3-bit ALU op code
//                and flags whether the combination is a supported R/I op.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_op_decode (
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [2:0] alu_ctrl,
  output logic       legal
);
  import ctrl_pkg::*;

  logic w_is_r;
  logic w_is_alu_op;

  assign w_is_r      = (opcode == OP_R);
  assign w_is_alu_op = (opcode == OP_R) || (opcode == OP_I);

  // funct3 selects the operation; funct7[5] only matters for R-type (sub)
  always_comb begin
    alu_ctrl = ALU_ADD;
    legal    = 1'b0;
    case (funct3)
      3'b000: begin
        alu_ctrl = (w_is_r && funct7_5) ? ALU_SUB : ALU_ADD;
        legal    = 1'b1;
      end
      3'b100: begin
        alu_ctrl = ALU_XOR;
        legal    = !(w_is_r && funct7_5);
      end
      3'b110: begin
        alu_ctrl = ALU_OR;
        legal    = !(w_is_r && funct7_5);
      end
      3'b111: begin
        alu_ctrl = ALU_AND;
        legal    = !(w_is_r && funct7_5);
      end
      default: begin
        alu_ctrl = ALU_ADD;
        legal    = 1'b0;
      end
    endcase
    if (!w_is_alu_op) begin
      legal = 1'b0;
    end
  end

endmodule : alu_op_decode
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl
//  Description : Multi-cycle FSM controller for the RV32I-subset datapath.
//                Fetches over valid/ready, decodes latched fields and drives
//                mux selects, strobes and the ALU op code.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] instr,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic                  EQ,
  input  logic                  mem_ready,
  output logic [2:0]            ALUctrl,
  output logic [1:0]            ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [2:0]            ImmSrc,
  output logic [1:0]            ResultSrc,
  output logic                  PCsrc,
  output logic                  PCWrite,
  output logic                  IRWrite,
  output logic                  RegWrite,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic                  illegal
);
  import ctrl_pkg::*;

  state_t     r_state;
  logic [6:0] r_opcode;
  logic [2:0] r_funct3;
  logic       r_funct7_5;

  logic [2:0] w_alu_ctrl;
  logic       w_alu_legal;
  logic       w_decode_legal;
  state_t     w_decode_next;

  // Only opcode, funct3 and funct7[5] are needed by the controller
  logic w_unused_instr_bits;
  assign w_unused_instr_bits = ^{instr[DATA_WIDTH-1:31], instr[29:15], instr[11:7]};

  alu_op_decode u_alu_op_decode (
    .opcode   (r_opcode),
    .funct3   (r_funct3),
    .funct7_5 (r_funct7_5),
    .alu_ctrl (w_alu_ctrl),
    .legal    (w_alu_legal)
  );

  // Legality check and dispatch target for the DECODE state
  always_comb begin
    w_decode_legal = 1'b0;
    w_decode_next  = S_FETCH;
    case (r_opcode)
      OP_R: begin
        w_decode_legal = w_alu_legal;
        w_decode_next  = S_EXEC_R;
      end
      OP_I: begin
        w_decode_legal = w_alu_legal;
        w_decode_next  = S_EXEC_I;
      end
      OP_LOAD, OP_STORE: begin
        w_decode_legal = (r_funct3 == 3'b010);
        w_decode_next  = S_MEM_ADDR;
      end
      OP_BRANCH: begin
        w_decode_legal = (r_funct3 == 3'b000) || (r_funct3 == 3'b001);
        w_decode_next  = S_BRANCH;
      end
      OP_JAL: begin
        w_decode_legal = 1'b1;
        w_decode_next  = S_JAL;
      end
      default: begin
        w_decode_legal = 1'b0;
        w_decode_next  = S_FETCH;
      end
    endcase
    if (!w_decode_legal) begin
      w_decode_next = S_FETCH;
    end
  end

  // State register and instruction-field latch
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_FETCH;
      r_opcode   <= 7'd0;
      r_funct3   <= 3'd0;
      r_funct7_5 <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (instr_valid) begin
            r_opcode   <= instr[6:0];
            r_funct3   <= instr[14:12];
            r_funct7_5 <= instr[30];
            r_state    <= S_DECODE;
          end
        end
        S_DECODE:           r_state <= w_decode_next;
        S_EXEC_R, S_EXEC_I: r_state <= S_ALU_WB;
        S_ALU_WB:           r_state <= S_FETCH;
        S_MEM_ADDR:         r_state <= (r_opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:           if (mem_ready) r_state <= S_MEM_WB;
        S_MEM_WB:           r_state <= S_FETCH;
        S_MEM_WR:           if (mem_ready) r_state <= S_FETCH;
        S_BRANCH, S_JAL:    r_state <= S_FETCH;
        default:            r_state <= S_FETCH;
      endcase
    end
  end

  // Moore outputs; fetch strobes gated by instr_valid, branch PCWrite by EQ,
  // and everything forced low while reset is asserted
  always_comb begin
    instr_ready = 1'b0;
    ALUctrl     = ALU_ADD;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_RS2;
    ImmSrc      = imm_src_of(r_opcode);
    ResultSrc   = RES_ALUOUT;
    PCsrc       = 1'b0;
    PCWrite     = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    illegal     = 1'b0;
    case (r_state)
      S_FETCH: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          ALUSrcB = SRCB_FOUR;
        end
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        illegal = !w_decode_legal;
      end
      S_EXEC_R: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        ALUctrl = w_alu_ctrl;
      end
      S_EXEC_I: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ALUctrl = w_alu_ctrl;
      end
      S_ALU_WB: begin
        RegWrite  = 1'b1;
        ResultSrc = RES_ALUOUT;
      end
      S_MEM_ADDR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEM_RD:   MemRead = 1'b1;
      S_MEM_WB: begin
        RegWrite  = 1'b1;
        ResultSrc = RES_MEM;
      end
      S_MEM_WR:   MemWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        ALUctrl = ALU_SUB;
        PCsrc   = 1'b1;
        PCWrite = r_funct3[0] ? !EQ : EQ;
      end
      S_JAL: begin
        PCWrite   = 1'b1;
        PCsrc     = 1'b1;
        RegWrite  = 1'b1;
        ResultSrc = RES_PC;
      end
      default: ;
    endcase
    if (!rst_n) begin
      instr_ready = 1'b0;
      ALUctrl     = 3'b000;
      ALUSrcA     = 2'b00;
      ALUSrcB     = 2'b00;
      ImmSrc      = 3'b000;
      ResultSrc   = 2'b00;
      PCsrc       = 1'b0;
      PCWrite     = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      illegal     = 1'b0;
    end
  end

endmodule : multicycle_ctrl
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_ctrl
//  Description : Self-checking bench for multicycle_ctrl: directed scenarios
//                plus randomized instructions against a per-instruction
//                summary model (latency, strobe counts, selects).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        EQ;
  logic        mem_ready;
  logic [2:0]  ALUctrl;
  logic [1:0]  ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [2:0]  ImmSrc;
  logic [1:0]  ResultSrc;
  logic        PCsrc, PCWrite, IRWrite, RegWrite, MemRead, MemWrite, illegal;

  int n_checks = 0;
  int n_fail   = 0;

  // per-instruction observations
  int         obs_cycles, obs_reg, obs_mrd, obs_mwr, obs_pcw, obs_pcw_src, obs_ill;
  logic [1:0] obs_res;
  logic [2:0] obs_imm, obs_alu;
  logic       obs_alu_seen, obs_fetch_ok, obs_timeout;

  // model expectations
  int         exp_cycles, exp_reg, exp_mrd, exp_mwr, exp_pcw, exp_ill;
  logic [1:0] exp_res;
  logic [2:0] exp_imm, exp_alu;
  logic       exp_alu_chk;

  always #5 clk = ~clk;

  multicycle_ctrl #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .EQ(EQ), .mem_ready(mem_ready),
    .ALUctrl(ALUctrl), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ResultSrc(ResultSrc), .PCsrc(PCsrc), .PCWrite(PCWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .illegal(illegal)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one instruction from FETCH and summarise the controller's behaviour
  // until it is ready for the next fetch
  task automatic run_instr(input logic [31:0] ins, input int waits, input logic eq);
    int  k;
    int  memc;
    logic done;
    obs_reg = 0; obs_mrd = 0; obs_mwr = 0; obs_pcw = 0; obs_pcw_src = 0; obs_ill = 0;
    obs_res = 2'b00; obs_imm = 3'b000; obs_alu = 3'b000; obs_alu_seen = 1'b0;
    instr = ins; instr_valid = 1'b1; EQ = eq; mem_ready = 1'b0;
    #1;
    obs_fetch_ok = instr_ready && IRWrite && PCWrite && !PCsrc &&
                   (ALUSrcA == 2'b00) && (ALUSrcB == 2'b10) && (ALUctrl == 3'b000);
    tick();
    instr_valid = 1'b0;
    instr = $urandom;
    k = 0; memc = 0; done = 1'b0;
    while (!done && k < 64) begin
      mem_ready = (memc >= waits);
      #1;
      if (instr_ready) begin
        done = 1'b1;
      end else begin
        if (k == 0) obs_imm = ImmSrc;
        if (RegWrite) begin obs_reg++; obs_res = ResultSrc; end
        if (MemRead) obs_mrd++;
        if (MemWrite) obs_mwr++;
        if (MemRead || MemWrite) memc++;
        if (PCWrite) begin obs_pcw++; if (PCsrc) obs_pcw_src++; end
        if (illegal) obs_ill++;
        if (ALUSrcA == 2'b10) begin obs_alu = ALUctrl; obs_alu_seen = 1'b1; end
        tick();
        k++;
      end
    end
    obs_timeout = !done;
    obs_cycles  = k + 1;
  endtask

  // Reference: what an instruction should do, from the ISA-subset rules
  task automatic model(input logic [31:0] ins, input int waits, input logic eq);
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       alu_f3_ok;
    logic [2:0] alu_code;
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[30];
    exp_cycles = 2; exp_ill = 1; exp_reg = 0; exp_mrd = 0; exp_mwr = 0; exp_pcw = 0;
    exp_res = 2'b00; exp_alu = 3'b000; exp_alu_chk = 1'b0;
    case (op)
      7'b0100011: exp_imm = 3'b001;
      7'b1100011: exp_imm = 3'b010;
      7'b1101111: exp_imm = 3'b011;
      default:    exp_imm = 3'b000;
    endcase
    alu_f3_ok = (f3 == 3'd0) || (f3 == 3'd4) || (f3 == 3'd6) || (f3 == 3'd7);
    case (f3)
      3'd4:    alu_code = 3'd4;
      3'd6:    alu_code = 3'd3;
      3'd7:    alu_code = 3'd2;
      default: alu_code = (op == 7'b0110011 && f7) ? 3'd1 : 3'd0;
    endcase
    if (op == 7'b0110011 && alu_f3_ok && !(f7 && f3 != 3'd0)) begin
      exp_ill = 0; exp_cycles = 4; exp_reg = 1; exp_alu = alu_code; exp_alu_chk = 1'b1;
    end else if (op == 7'b0010011 && alu_f3_ok) begin
      exp_ill = 0; exp_cycles = 4; exp_reg = 1; exp_alu = alu_code; exp_alu_chk = 1'b1;
    end else if (op == 7'b0000011 && f3 == 3'd2) begin
      exp_ill = 0; exp_cycles = 5 + waits; exp_mrd = waits + 1; exp_reg = 1;
      exp_res = 2'b01; exp_alu_chk = 1'b1;
    end else if (op == 7'b0100011 && f3 == 3'd2) begin
      exp_ill = 0; exp_cycles = 4 + waits; exp_mwr = waits + 1; exp_alu_chk = 1'b1;
    end else if (op == 7'b1100011 && f3 < 3'd2) begin
      exp_ill = 0; exp_cycles = 3; exp_pcw = ((f3 == 3'd0) == eq) ? 1 : 0;
      exp_alu = 3'd1; exp_alu_chk = 1'b1;
    end else if (op == 7'b1101111) begin
      exp_ill = 0; exp_cycles = 3; exp_pcw = 1; exp_reg = 1; exp_res = 2'b11;
    end
  endtask

  task automatic test_reset();
    logic [19:0] outs;
    rst_n = 1'b0; instr = 32'h002081B3; instr_valid = 1'b1; mem_ready = 1'b1; EQ = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      outs = {instr_ready, ALUctrl, ALUSrcA, ALUSrcB, ImmSrc, ResultSrc,
              PCsrc, PCWrite, IRWrite, RegWrite, MemRead, MemWrite, illegal};
      n_checks++;
      if (outs !== 20'd0) begin
        n_fail++; $display("FAIL reset_outputs cycle %0d: got %h want 00000", c, outs);
      end
    end
    instr_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (instr_ready !== 1'b1 || IRWrite !== 1'b0 || ImmSrc !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_release: ready=%b irw=%b imm=%b want 1 0 000", instr_ready, IRWrite, ImmSrc);
    end
  endtask

  task automatic test_rtype();
    instr = 32'h002081B3; instr_valid = 1'b1; mem_ready = 1'b1; EQ = 1'b0;
    #1;
    n_checks++;
    if ({instr_ready, IRWrite, PCWrite, PCsrc, ALUSrcA, ALUSrcB, ALUctrl} !== 11'b1110_00_10_000) begin
      n_fail++;
      $display("FAIL add_fetch: got %b want 11100010000",
               {instr_ready, IRWrite, PCWrite, PCsrc, ALUSrcA, ALUSrcB, ALUctrl});
    end
    tick();
    instr_valid = 1'b0;
    n_checks++;
    if ({instr_ready, ALUSrcA, ALUSrcB, RegWrite, illegal} !== 7'b0_01_01_0_0) begin
      n_fail++;
      $display("FAIL add_decode: got %b want 0010100", {instr_ready, ALUSrcA, ALUSrcB, RegWrite, illegal});
    end
    tick();
    n_checks++;
    if ({ALUctrl, ALUSrcA, ALUSrcB, RegWrite} !== 8'b000_10_00_0) begin
      n_fail++;
      $display("FAIL add_exec: got %b want 00010000", {ALUctrl, ALUSrcA, ALUSrcB, RegWrite});
    end
    tick();
    n_checks++;
    if ({RegWrite, ResultSrc, instr_ready} !== 4'b1_00_0) begin
      n_fail++;
      $display("FAIL add_wb: got %b want 1000", {RegWrite, ResultSrc, instr_ready});
    end
    tick();
    n_checks++;
    if (instr_ready !== 1'b1) begin
      n_fail++; $display("FAIL add_return: ready=%b want 1", instr_ready);
    end
    run_instr(32'h402081B3, 0, 1'b0);
    n_checks++;
    if (obs_alu !== 3'b001 || !obs_alu_seen || obs_cycles != 4) begin
      n_fail++; $display("FAIL sub_aluctrl: alu=%b cycles=%0d want 001 4", obs_alu, obs_cycles);
    end
  endtask

  task automatic test_branch();
    logic [31:0] ins;
    logic        eq;
    int          want;
    for (int t = 0; t < 4; t++) begin
      ins  = (t < 2) ? 32'h00208463 : 32'h00209463;
      eq   = t[0];
      want = ((t < 2) == eq) ? 1 : 0;
      run_instr(ins, 0, eq);
      n_checks++;
      if (obs_pcw != want || obs_pcw_src != want || obs_cycles != 3 || obs_alu !== 3'b001) begin
        n_fail++;
        $display("FAIL branch_%0d: pcw=%0d src=%0d cycles=%0d alu=%b want %0d %0d 3 001",
                 t, obs_pcw, obs_pcw_src, obs_cycles, obs_alu, want, want);
      end
    end
  endtask

  task automatic test_load_wait();
    run_instr(32'h0000A183, 3, 1'b0);
    n_checks++;
    if (obs_mrd != 4 || obs_reg != 1 || obs_res !== 2'b01 || obs_cycles != 8 || obs_mwr != 0) begin
      n_fail++;
      $display("FAIL lw_wait: mrd=%0d reg=%0d res=%b cycles=%0d mwr=%0d want 4 1 01 8 0",
               obs_mrd, obs_reg, obs_res, obs_cycles, obs_mwr);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] ins;
    for (int t = 0; t < 2; t++) begin
      ins = (t == 0) ? 32'hFFFFFFFF : 32'h002091B3;
      run_instr(ins, 0, 1'b1);
      n_checks++;
      if (obs_ill != 1 || obs_reg != 0 || obs_mwr != 0 || obs_pcw != 0 || obs_cycles != 2) begin
        n_fail++;
        $display("FAIL illegal_%0d: ill=%0d reg=%0d mwr=%0d pcw=%0d cycles=%0d want 1 0 0 0 2",
                 t, obs_ill, obs_reg, obs_mwr, obs_pcw, obs_cycles);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] ins;
    logic [6:0]  ops [6];
    int          waits;
    logic        eq;
    ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011;
    ops[3] = 7'b0100011; ops[4] = 7'b1100011; ops[5] = 7'b1101111;
    for (int n = 0; n < 80; n++) begin
      ins = $urandom;
      if ($urandom_range(0, 6) != 0) ins[6:0] = ops[$urandom_range(0, 5)];
      if ($urandom_range(0, 1) == 1) begin
        ins[30] = 1'b0;
        case (ins[6:0])
          7'b0000011, 7'b0100011: ins[14:12] = 3'b010;
          7'b1100011:             ins[14:12] = {2'b00, ins[12]};
          default:                if (ins[14:12] == 3'b001) ins[14:12] = 3'b110;
        endcase
      end
      waits = $urandom_range(0, 3);
      eq    = $urandom_range(0, 1);
      model(ins, waits, eq);
      run_instr(ins, waits, eq);
      n_checks++;
      if (obs_timeout || obs_cycles != exp_cycles || !obs_fetch_ok) begin
        n_fail++;
        $display("FAIL rand_latency %h: cycles=%0d timeout=%b fetch_ok=%b want %0d 0 1",
                 ins, obs_cycles, obs_timeout, obs_fetch_ok, exp_cycles);
      end
      n_checks++;
      if (obs_reg != exp_reg || obs_res !== exp_res || obs_mrd != exp_mrd || obs_mwr != exp_mwr) begin
        n_fail++;
        $display("FAIL rand_strobes %h: reg=%0d res=%b mrd=%0d mwr=%0d want %0d %b %0d %0d",
                 ins, obs_reg, obs_res, obs_mrd, obs_mwr, exp_reg, exp_res, exp_mrd, exp_mwr);
      end
      n_checks++;
      if (obs_pcw != exp_pcw || obs_pcw_src != exp_pcw || obs_ill != exp_ill || obs_imm !== exp_imm) begin
        n_fail++;
        $display("FAIL rand_ctrl %h: pcw=%0d src=%0d ill=%0d imm=%b want %0d %0d %0d %b",
                 ins, obs_pcw, obs_pcw_src, obs_ill, obs_imm, exp_pcw, exp_pcw, exp_ill, exp_imm);
      end
      if (exp_alu_chk) begin
        n_checks++;
        if (!obs_alu_seen || obs_alu !== exp_alu) begin
          n_fail++;
          $display("FAIL rand_alu %h: alu=%b seen=%b want %b", ins, obs_alu, obs_alu_seen, exp_alu);
        end
      end
    end
  endtask

  task automatic test_store_reset();
    instr = 32'h0020A023; instr_valid = 1'b1; mem_ready = 1'b0; EQ = 1'b0;
    #1;
    tick();
    instr_valid = 1'b0;
    tick();
    tick();
    n_checks++;
    if (MemWrite !== 1'b1) begin
      n_fail++; $display("FAIL sw_memwrite: got %b want 1", MemWrite);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (MemWrite !== 1'b0 || instr_ready !== 1'b0) begin
      n_fail++; $display("FAIL sw_reset_drop: memwrite=%b ready=%b want 0 0", MemWrite, instr_ready);
    end
    tick();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (instr_ready !== 1'b1 || MemWrite !== 1'b0 || ImmSrc !== 3'b000) begin
      n_fail++;
      $display("FAIL sw_reset_fetch: ready=%b memwrite=%b imm=%b want 1 0 000", instr_ready, MemWrite, ImmSrc);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_branch();
    test_load_wait();
    test_illegal();
    test_random();
    test_store_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_multicycle_ctrl
`default_nettype wire
